// File: rtl/conv_window_buffer.sv
// conv_window_buffer: raster-stream sliding KERNELxKERNEL window generator
// Holds (KERNEL-1) lines plus KERNEL pixels in a tapped chain and flags in-image windows.
module conv_window_buffer #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL       = 3,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                clear,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0] window_out,
  output logic                                window_valid,
  output logic                                frame_done,
  output logic [$clog2(IMAGE_WIDTH)-1:0]      col_idx,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]     row_idx
);
  localparam int cw = $clog2(IMAGE_WIDTH);
  localparam int rw = $clog2(IMAGE_HEIGHT);
  localparam int len = (KERNEL-1)*IMAGE_WIDTH + KERNEL;
  localparam logic [cw-1:0] col_last = cw'(IMAGE_WIDTH-1);
  localparam logic [rw-1:0] row_last = rw'(IMAGE_HEIGHT-1);
  localparam logic [cw-1:0] col_fill = cw'(KERNEL-1);
  localparam logic [rw-1:0] row_fill = rw'(KERNEL-1);
  logic [DATA_WIDTH-1:0] chain [len];
  logic end_col, end_row;
  assign end_col = col_idx == col_last;
  assign end_row = row_idx == row_last;
  always_ff @(posedge clock or posedge reset) begin
    if (reset || clear) begin
      for (int i = 0; i < len; i++) chain[i] <= '0;
      col_idx      <= '0;
      row_idx      <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else if (in_valid) begin
      chain[0] <= in_data;
      for (int i = 1; i < len; i++) chain[i] <= chain[i-1];
      col_idx      <= end_col ? '0 : col_idx + cw'(1);
      row_idx      <= !end_col ? row_idx : end_row ? '0 : row_idx + rw'(1);
      window_valid <= row_idx >= row_fill && col_idx >= col_fill;
      frame_done   <= end_col && end_row;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end
  end
  // Tap (r,c) sits r lines plus c pixels behind the newest pixel.
  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    for (genvar c = 0; c < KERNEL; c++) begin : g_col
      assign window_out[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = chain[r*IMAGE_WIDTH+c];
    end
  end
endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: table vectors, directed corner cases and randomized
// stimulus checked against a pixel-history reference model.
module tb_conv_window_buffer;
  localparam int DW = 16, K = 3, W = 5, H = 4, L = (K-1)*W + K;
  logic clock = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [K*K*DW-1:0] window_out;
  logic window_valid, frame_done;
  logic [2:0] col_idx;
  logic [1:0] row_idx;

  conv_window_buffer #(.DATA_WIDTH(DW), .KERNEL(K), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .window_out(window_out), .window_valid(window_valid), .frame_done(frame_done),
    .col_idx(col_idx), .row_idx(row_idx));

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;
  int hist[$];
  int n = 0;
  bit last_acc = 1'b0;

  typedef struct {
    logic [DW-1:0] d;
    logic          ev;
    logic [DW-1:0] e00;
    logic [DW-1:0] e22;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] tap(input int r, input int c);
    return 32'(window_out[(r*K+c)*DW +: DW]);
  endfunction

  function automatic logic [31:0] b(input logic x);
    return {31'd0, x};
  endfunction

  task automatic model_reset();
    hist.delete();
    n = 0;
    last_acc = 1'b0;
  endtask

  task automatic check_model();
    int p;
    bit ev, ed;
    p = (n > 0) ? n - 1 : 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        chk($sformatf("tap%0d%0d", r, c), tap(r, c),
            (r*W+c < hist.size()) ? 32'(hist[r*W+c]) : 32'd0);
    ev = last_acc && ((p / W) % H) >= K-1 && (p % W) >= K-1;
    ed = last_acc && (p % (W*H)) == W*H - 1;
    chk("window_valid", b(window_valid), b(ev));
    chk("frame_done", b(frame_done), b(ed));
    chk("col_idx", 32'(col_idx), 32'(n % W));
    chk("row_idx", 32'(row_idx), 32'((n / W) % H));
  endtask

  task automatic step(input bit v, input int d, input bit clr);
    in_valid = v;
    in_data = DW'(d);
    clear = clr;
    @(posedge clock);
    #1;
    if (clr) model_reset();
    else if (v) begin
      hist.push_front(d & 16'hFFFF);
      if (hist.size() > L) void'(hist.pop_back());
      n++;
      last_acc = 1'b1;
    end else last_acc = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    check_model();
  endtask

  initial begin
    logic [19:0] vmask;
    int pulses;
    vmask = 20'hE7000;
    for (int i = 1; i <= 20; i++)
      tbl[i-1] = '{d: DW'(i), ev: vmask[i-1], e00: DW'(i), e22: DW'(i >= 13 ? i - 12 : 0)};

    #12;
    chk("rst_window", b(|window_out), 32'd0);
    chk("rst_valid", b(window_valid), 32'd0);
    chk("rst_done", b(frame_done), 32'd0);
    chk("rst_col", 32'(col_idx), 32'd0);
    chk("rst_row", 32'(row_idx), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, int'(tbl[i].d), 1'b0);
      chk("tbl_valid", b(window_valid), b(tbl[i].ev));
      chk("tbl_tap00", tap(0, 0), 32'(tbl[i].e00));
      chk("tbl_tap22", tap(2, 2), 32'(tbl[i].e22));
      chk("tbl_done", b(frame_done), b(i == 19));
      if (i == 12) begin
        chk("first_tap02", tap(0, 2), 32'd11);
        chk("first_tap11", tap(1, 1), 32'd7);
      end
      if (window_valid) pulses++;
    end
    chk("tbl_pulses", 32'(pulses), 32'd6);

    step(1'b0, 0, 1'b1);
    pulses = 0;
    for (int i = 1; i <= 20; ) begin
      if ($urandom_range(0, 2) == 0) begin
        step(1'b0, int'($urandom_range(0, 65535)), 1'b0);
        chk("gap_valid", b(window_valid), 32'd0);
      end else begin
        step(1'b1, i, 1'b0);
        if (i == 13) chk("gap_tap22", tap(2, 2), 32'd1);
        if (window_valid) pulses++;
        i++;
      end
    end
    chk("gap_pulses", 32'(pulses), 32'd6);

    step(1'b0, 0, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, i, 1'b0);
      if (i == 20 || i == 40) chk("wrap_done", b(frame_done), 32'd1);
      if (i == 32) chk("wrap_pre_valid", b(window_valid), 32'd0);
      if (i == 33) begin
        chk("wrap_valid33", b(window_valid), 32'd1);
        chk("wrap_tap22", tap(2, 2), 32'd21);
      end
    end
    chk("wrap_col", 32'(col_idx), 32'd0);
    chk("wrap_row", 32'(row_idx), 32'd0);

    for (int i = 1; i <= 9; i++) step(1'b1, 100 + i, 1'b0);
    step(1'b1, 99, 1'b1);
    chk("clr_window", b(|window_out), 32'd0);
    for (int i = 1; i <= 13; i++) begin
      step(1'b1, 200 + i, 1'b0);
      chk("clr_valid", b(window_valid), b(i == 13));
    end

    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("arst_window", b(|window_out), 32'd0);
    chk("arst_valid", b(window_valid), 32'd0);
    chk("arst_col", 32'(col_idx), 32'd0);
    chk("arst_row", 32'(row_idx), 32'd0);
    #1;
    reset = 1'b0;
    model_reset();
    step(1'b0, 0, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      step(1'b1, 300 + i, 1'b0);
      chk("arst_fill", b(window_valid), b(i == 13));
    end

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)), $urandom_range(0, 59) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Parametrised sliding-window generator for the convolver datapath. It is the next generation of the flat shift register.
- Accepts a raster-order pixel stream under a valid qualifier and holds (KERNEL-1) full image lines plus KERNEL pixels in a tapped delay chain.
- Presents a KERNELxKERNEL window every cycle, with a window_valid flag that suppresses windows which straddle row edges or precede the fill.
- Tracks row/column position and pulses frame_done at the end of each frame.

Parameters:
- DATA_WIDTH, 16, bits per pixel
- KERNEL, 3, window edge length (>=2)
- IMAGE_WIDTH, 8, pixels per row (>=KERNEL)
- IMAGE_HEIGHT, 8, rows per frame (>=KERNEL)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- clear  input  1  synchronous clear, same effect as reset
- in_valid  input  1  in_data is accepted on this edge
- in_data  input  DATA_WIDTH  pixel, raster order
- window_out  output  KERNEL*KERNEL*DATA_WIDTH  flattened window
- window_valid  output  1  window_out is a complete in-image window
- frame_done  output  1  one-cycle pulse after last pixel of frame
- col_idx  output  clog2(IMAGE_WIDTH)  column of next pixel to be accepted
- row_idx  output  clog2(IMAGE_HEIGHT)  row of next pixel to be accepted

Behaviour:
- Reset is asynchronous, active-high, on signal reset; clock is clock.
- Reset values: all chain registers 0, window_out 0, window_valid 0, frame_done 0, col_idx 0, row_idx 0.
- clear has identical effect synchronously and has priority over in_valid.
- Chain: L = (KERNEL-1)*IMAGE_WIDTH + KERNEL registers, element 0 newest. The chain shifts by one only on edges with in_valid=1; with in_valid=0 all state holds (no bubbles inserted).
- Tap mapping: window element (r,c), with r,c in 0..KERNEL-1, is chain[r*IMAGE_WIDTH + c]. It occupies window_out bits [(r*KERNEL+c+1)*DATA_WIDTH-1 : (r*KERNEL+c)*DATA_WIDTH]. (0,0) is the newest pixel; (KERNEL-1,KERNEL-1) is the oldest (top-left of image window).
- window_out is a direct wire view of registers, with zero extra latency after the accepting edge.
- Position counters advance on each accepted pixel:
  - col_idx wraps IMAGE_WIDTH-1 -> 0 and increments row_idx.
  - row_idx wraps IMAGE_HEIGHT-1 -> 0 at end of frame.
- window_valid is registered and updates only on accepting edges. It is set to 1 iff the accepted pixel had row >= KERNEL-1 and col >= KERNEL-1, and set to 0 otherwise. On non-accepting edges it is cleared to 0, so each window is flagged for exactly one cycle.
- frame_done is 1 for exactly one cycle following the edge that accepts pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1); otherwise it is 0.
- Frame boundary: the chain is NOT flushed between frames. Fill logic restarts from counters, so no window mixing two frames is ever flagged valid.
- Windows per frame: (IMAGE_HEIGHT-KERNEL+1)*(IMAGE_WIDTH-KERNEL+1).
- Reset or clear mid-frame: all outputs return to reset values at once; the next accepted pixel is treated as (0,0).
- No backpressure: the block always accepts.

Test Plan:
- Fill and first window:
  - Setup: K=3, W=5, H=4; stream pixels 1..20 with in_valid held high.
  - window_valid is first high after the 13th pixel (row2, col2).
  - Window at that point: tap(0,0)=13, tap(0,2)=11, tap(1,1)=7, tap(2,2)=1.
- Row-edge suppression and window count:
  - Same stream: window_valid is low after pixels 16 and 17 (cols 0, 1 of row 3) and high after 18.
  - Exactly 6 valid pulses per frame.
- Valid gaps:
  - Insert random in_valid=0 cycles into the same stream.
  - Window contents and valid count are identical to the gap-free case.
  - window_valid is never high in a gap cycle.
- Frame wrap:
  - Stream 40 pixels.
  - frame_done pulses after pixels 20 and 40.
  - row_idx/col_idx return to 0.
  - Frame 2 first valid window is after pixel 33, with tap(2,2)=21.
- Clear/reset mid-frame:
  - Assert clear after pixel 9: next cycle counters are 0, window_out is all 0, and the next valid window is 13 pixels later.
  - Repeat with async reset asserted between clock edges: outputs go to 0 before the next edge.
